// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID/EX control pipe: opcodes, functs, ALU codes,
// the decoded control bundle and the per-edge action selector.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       link;
    logic       md_start;
    logic       illegal;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BUBBLE = '{alu_op: ALU_NOP, default: 1'b0};

  typedef enum logic [1:0] {
    DST_RT,
    DST_RD,
    DST_LINK
  } dst_t;

  typedef enum logic [1:0] {
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_STALL,
    ACT_ISSUE
  } act_t;

  function automatic logic is_md_issue(logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

  function automatic logic is_md_dep(logic [5:0] f);
    return is_md_issue(f) || (f == FN_MFHI) || (f == FN_MFLO);
  endfunction

endpackage

// File: rtl/id_ex_ctrl_pipe_if.sv
// ID-stage instruction fields in, ID/EX control bundle and PC/IF-ID enables out.
interface id_ex_ctrl_pipe_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic [4:0]         id_rd;
  logic               if_flush;
  logic               mem_stall;
  logic               pc_write;
  logic               ifid_write;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_mem_to_reg;
  logic               ex_alu_src;
  logic               ex_branch;
  logic               ex_branch_ne;
  logic               ex_jump;
  logic               ex_link;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [4:0]         ex_rs;
  logic [4:0]         ex_rt;
  logic [4:0]         ex_wr_reg;
  logic               ex_md_start;
  logic               ex_illegal;
  logic               md_busy;

  modport master (
    output opcode, funct, id_rs, id_rt, id_rd, if_flush, mem_stall,
    input  pc_write, ifid_write, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_branch, ex_branch_ne, ex_jump, ex_link, ex_alu_op, ex_rs, ex_rt,
           ex_wr_reg, ex_md_start, ex_illegal, md_busy
  );

  modport slave (
    input  opcode, funct, id_rs, id_rt, id_rd, if_flush, mem_stall,
    output pc_write, ifid_write, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_branch, ex_branch_ne, ex_jump, ex_link, ex_alu_op, ex_rs, ex_rt,
           ex_wr_reg, ex_md_start, ex_illegal, md_busy
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing the control bundle plus the
// hazard-related side information the pipe register needs.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output dst_t       dst,
  output logic       uses_rt,
  output logic       md_dep
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    dst     = DST_RT;
    uses_rt = 1'b0;
    md_dep  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.md_start  = is_md_issue(funct);
        dst            = DST_RD;
        uses_rt        = 1'b1;
        md_dep         = is_md_dep(funct);
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        uses_rt        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (opcode == OP_BNE);
        ctrl.alu_op    = ALU_SUB;
        uses_rt        = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        case (opcode)
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        dst            = DST_LINK;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// Decodes the ID instruction, resolves load-use and mult/div hazards and
// loads the ID/EX control register; drives the PC and IF/ID write enables.
module id_ex_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int MD_LATENCY = 4,
  parameter int HAZARD_EN  = 1,
  parameter int LINK_REG   = 31
) (
  input logic              clk,
  input logic              reset,
  id_ex_ctrl_pipe_if.slave bus
);

  ctrl_t      dec_ctrl;
  dst_t       dec_dst;
  logic       dec_uses_rt;
  logic       dec_md_dep;

  ctrl_t      ctrl_reg, ctrl_next;
  logic [4:0] rs_reg, rs_next;
  logic [4:0] rt_reg, rt_next;
  logic [4:0] dst_reg, dst_next;
  logic [3:0] md_cnt_reg, md_cnt_next;
  logic [3:0] md_cnt_dec;
  logic       load_use;
  logic       md_hazard;
  act_t       act;

  ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .ctrl    (dec_ctrl),
    .dst     (dec_dst),
    .uses_rt (dec_uses_rt),
    .md_dep  (dec_md_dep)
  );

  always_comb begin
    load_use  = (HAZARD_EN != 0) && ctrl_reg.mem_read && (rt_reg != 5'd0) &&
                ((rt_reg == bus.id_rs) || ((rt_reg == bus.id_rt) && dec_uses_rt));
    md_hazard = (md_cnt_reg != 4'd0) && dec_md_dep;
    if (bus.mem_stall)                act = ACT_FREEZE;
    else if (bus.if_flush)            act = ACT_FLUSH;
    else if (load_use || md_hazard)   act = ACT_STALL;
    else                              act = ACT_ISSUE;
  end

  assign md_cnt_dec = (md_cnt_reg != 4'd0) ? md_cnt_reg - 4'd1 : 4'd0;

  always_comb begin
    ctrl_next   = ctrl_reg;
    rs_next     = rs_reg;
    rt_next     = rt_reg;
    dst_next    = dst_reg;
    md_cnt_next = md_cnt_reg;
    case (act)
      ACT_FLUSH, ACT_STALL: begin
        ctrl_next   = CTRL_BUBBLE;
        rs_next     = 5'd0;
        rt_next     = 5'd0;
        dst_next    = 5'd0;
        md_cnt_next = md_cnt_dec;
      end
      ACT_ISSUE: begin
        ctrl_next   = dec_ctrl;
        md_cnt_next = dec_ctrl.md_start ? 4'(MD_LATENCY) : md_cnt_dec;
        // An undefined opcode travels as a bubble, so its register fields are dropped.
        if (dec_ctrl.illegal) begin
          rs_next  = 5'd0;
          rt_next  = 5'd0;
          dst_next = 5'd0;
        end else begin
          rs_next = bus.id_rs;
          rt_next = bus.id_rt;
          case (dec_dst)
            DST_RD:   dst_next = bus.id_rd;
            DST_LINK: dst_next = 5'(LINK_REG);
            default:  dst_next = bus.id_rt;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg   <= CTRL_BUBBLE;
      rs_reg     <= 5'd0;
      rt_reg     <= 5'd0;
      dst_reg    <= 5'd0;
      md_cnt_reg <= 4'd0;
    end else begin
      ctrl_reg   <= ctrl_next;
      rs_reg     <= rs_next;
      rt_reg     <= rt_next;
      dst_reg    <= dst_next;
      md_cnt_reg <= md_cnt_next;
    end
  end

  assign bus.pc_write      = reset || (act == ACT_FLUSH) || (act == ACT_ISSUE);
  assign bus.ifid_write    = bus.pc_write;
  assign bus.ex_reg_write  = ctrl_reg.reg_write;
  assign bus.ex_mem_read   = ctrl_reg.mem_read;
  assign bus.ex_mem_write  = ctrl_reg.mem_write;
  assign bus.ex_mem_to_reg = ctrl_reg.mem_to_reg;
  assign bus.ex_alu_src    = ctrl_reg.alu_src;
  assign bus.ex_branch     = ctrl_reg.branch;
  assign bus.ex_branch_ne  = ctrl_reg.branch_ne;
  assign bus.ex_jump       = ctrl_reg.jump;
  assign bus.ex_link       = ctrl_reg.link;
  assign bus.ex_md_start   = ctrl_reg.md_start;
  assign bus.ex_illegal    = ctrl_reg.illegal;
  // NOP widens to all ones; real ALU codes are zero-extended.
  assign bus.ex_alu_op     = (ctrl_reg.alu_op == ALU_NOP) ? {ALUOP_W{1'b1}} : ALUOP_W'(ctrl_reg.alu_op);
  assign bus.ex_rs         = rs_reg;
  assign bus.ex_rt         = rt_reg;
  assign bus.ex_wr_reg     = dst_reg;
  assign bus.md_busy       = (md_cnt_reg != 4'd0);

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed vector table plus randomized traffic against an instruction-level model.
module tb_id_ex_ctrl_pipe;

  localparam int MD_LAT = 4;
  localparam logic [5:0] R = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] ADDI = 6'h08, SLTI = 6'h0A, ANDI = 6'h0C, ORI = 6'h0D;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_MULT = 6'h18, F_DIV = 6'h1A;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_ctrl_pipe_if #(.ALUOP_W(4)) bus ();

  id_ex_ctrl_pipe #(
    .ALUOP_W(4), .MD_LATENCY(MD_LAT), .HAZARD_EN(1), .LINK_REG(31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic rw; logic mr; logic mw; logic m2r; logic asrc; logic br; logic bne;
    logic jmp; logic lnk; logic mds; logic ill;
    logic [3:0] alu;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] wr;
  } ex_t;

  typedef struct {
    logic rst; logic [5:0] op; logic [5:0] fn; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd;
    logic fl; logic ms;
    logic pcw; logic rw; logic mr; logic [3:0] alu; logic [4:0] wr;
    logic [5:0] flags;  // {link, jump, branch, branch_ne, illegal, md_start}
    logic busy;
  } vec_t;

  vec_t vecs[$];
  ex_t  m_ex;
  int   m_md;

  logic [5:0] op_tab [0:13] = '{R, R, R, LW, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, SLTI, JAL, BAD};
  logic [5:0] fn_tab [0:5]  = '{F_ADD, F_SUB, F_MULT, F_DIV, F_MFHI, F_MFLO};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic ex_t idle_ex();
    ex_t e = '0;
    e.alu = 4'hF;
    return e;
  endfunction

  // What each instruction should look like once it sits in EX.
  function automatic ex_t model_decode(logic [5:0] op, logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    ex_t e = idle_ex();
    e.rs = rs; e.rt = rt; e.wr = rt;
    case (op)
      R:    begin e.rw = 1; e.wr = rd; e.mds = (fn == F_MULT || fn == F_DIV); end
      LW:   begin e.rw = 1; e.mr = 1; e.m2r = 1; e.asrc = 1; e.alu = 4'h2; end
      SW:   begin e.mw = 1; e.asrc = 1; e.alu = 4'h2; end
      BEQ:  begin e.br = 1; e.alu = 4'h6; end
      BNE:  begin e.br = 1; e.bne = 1; e.alu = 4'h6; end
      ADDI: begin e.rw = 1; e.asrc = 1; e.alu = 4'h2; end
      ANDI: begin e.rw = 1; e.asrc = 1; e.alu = 4'h0; end
      ORI:  begin e.rw = 1; e.asrc = 1; e.alu = 4'h1; end
      SLTI: begin e.rw = 1; e.asrc = 1; e.alu = 4'h7; end
      J:    begin e.jmp = 1; end
      JAL:  begin e.jmp = 1; e.lnk = 1; e.rw = 1; e.wr = 5'd31; end
      default: begin e = idle_ex(); e.ill = 1; end
    endcase
    return e;
  endfunction

  function automatic bit model_hazard();
    bit reads_rt = (bus.opcode inside {R, BEQ, BNE, SW});
    bit lu = m_ex.mr && (m_ex.rt != 0) &&
             ((m_ex.rt == bus.id_rs) || ((m_ex.rt == bus.id_rt) && reads_rt));
    bit md = (m_md > 0) && (bus.opcode == R) && (bus.funct inside {F_MULT, F_DIV, F_MFHI, F_MFLO});
    return lu || md;
  endfunction

  function automatic logic model_pc_write();
    if (reset) return 1'b1;
    if (bus.mem_stall) return 1'b0;
    if (bus.if_flush) return 1'b1;
    return !model_hazard();
  endfunction

  task automatic model_update();
    bit issue;
    issue = !bus.if_flush && !model_hazard();
    if (reset) begin
      m_ex = idle_ex();
      m_md = 0;
    end else if (!bus.mem_stall) begin
      if (issue && bus.opcode == R && (bus.funct == F_MULT || bus.funct == F_DIV)) m_md = MD_LAT;
      else if (m_md > 0) m_md = m_md - 1;
      m_ex = issue ? model_decode(bus.opcode, bus.funct, bus.id_rs, bus.id_rt, bus.id_rd) : idle_ex();
    end
  endtask

  function automatic ex_t dut_ex();
    ex_t e;
    e.rw = bus.ex_reg_write; e.mr = bus.ex_mem_read; e.mw = bus.ex_mem_write;
    e.m2r = bus.ex_mem_to_reg; e.asrc = bus.ex_alu_src; e.br = bus.ex_branch;
    e.bne = bus.ex_branch_ne; e.jmp = bus.ex_jump; e.lnk = bus.ex_link;
    e.mds = bus.ex_md_start; e.ill = bus.ex_illegal; e.alu = bus.ex_alu_op;
    e.rs = bus.ex_rs; e.rt = bus.ex_rt; e.wr = bus.ex_wr_reg;
    return e;
  endfunction

  // One clock: drive on the falling edge, check comb enables, then check registers after the rising edge.
  task automatic cycle(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl, input logic ms, output logic pcw);
    logic exp_pcw;
    @(negedge clk);
    reset = rst; bus.opcode = op; bus.funct = fn;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.if_flush = fl; bus.mem_stall = ms;
    #1;
    exp_pcw = model_pc_write();
    check("pc_write", bus.pc_write, exp_pcw);
    check("ifid_write", bus.ifid_write, exp_pcw);
    pcw = bus.pc_write;
    model_update();
    @(posedge clk);
    #1;
    check("ex_bundle", dut_ex(), m_ex);
    check("md_busy", bus.md_busy, (m_md > 0));
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic fl, input logic ms, input logic pcw, input logic rw,
                     input logic mr, input logic [3:0] alu, input logic [4:0] wr,
                     input logic [5:0] flags, input logic busy);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.rd = rd; v.fl = fl; v.ms = ms;
    v.pcw = pcw; v.rw = rw; v.mr = mr; v.alu = alu; v.wr = wr; v.flags = flags; v.busy = busy;
    vecs.push_back(v);
  endtask

  initial begin
    logic got_pcw;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic fl, ms, rst;

    m_ex = idle_ex(); m_md = 0;
    reset = 1'b1; bus.opcode = LW; bus.funct = 6'h0; bus.id_rs = 5'd1; bus.id_rt = 5'd5;
    bus.id_rd = 5'd0; bus.if_flush = 1'b0; bus.mem_stall = 1'b0;

    //  rst op    fn      rs rt rd fl ms | pcw rw mr alu  wr  flags      busy
    add(1, LW,   6'h0,   1, 5, 0, 0, 0,   1,  0, 0, 4'hF, 0,  6'b000000, 0);  // reset state
    add(1, LW,   6'h0,   1, 5, 0, 0, 0,   1,  0, 0, 4'hF, 0,  6'b000000, 0);
    add(0, LW,   6'h0,   1, 5, 0, 0, 0,   1,  1, 1, 4'h2, 5,  6'b000000, 0);  // LW after release
    add(0, R,    F_ADD,  5, 6, 9, 0, 0,   0,  0, 0, 4'hF, 0,  6'b000000, 0);  // load-use bubble
    add(0, R,    F_ADD,  5, 6, 9, 0, 0,   1,  1, 0, 4'hF, 9,  6'b000000, 0);
    add(0, LW,   6'h0,   1, 0, 0, 0, 0,   1,  1, 1, 4'h2, 0,  6'b000000, 0);  // LW to r0
    add(0, R,    F_ADD,  0, 0, 3, 0, 0,   1,  1, 0, 4'hF, 3,  6'b000000, 0);  // no stall on r0
    add(0, R,    F_MULT, 2, 3, 0, 1, 0,   1,  0, 0, 4'hF, 0,  6'b000000, 0);  // flushed MULT
    add(0, JAL,  6'h0,   0, 0, 0, 0, 0,   1,  1, 0, 4'hF, 31, 6'b110000, 0);
    add(0, BNE,  6'h0,   1, 2, 0, 0, 0,   1,  0, 0, 4'h6, 2,  6'b001100, 0);
    add(0, BAD,  6'h0,   1, 2, 3, 0, 0,   1,  0, 0, 4'hF, 0,  6'b000010, 0);  // illegal
    add(0, ADDI, 6'h0,   1, 4, 0, 0, 0,   1,  1, 0, 4'h2, 4,  6'b000000, 0);
    add(0, R,    F_MULT, 1, 2, 0, 0, 0,   1,  1, 0, 4'hF, 0,  6'b000001, 1);  // MULT issues
    add(0, R,    F_MFLO, 0, 0, 8, 0, 0,   0,  0, 0, 4'hF, 0,  6'b000000, 1);
    add(0, R,    F_MFLO, 0, 0, 8, 0, 0,   0,  0, 0, 4'hF, 0,  6'b000000, 1);
    add(0, R,    F_MFLO, 0, 0, 8, 0, 0,   0,  0, 0, 4'hF, 0,  6'b000000, 1);
    add(0, R,    F_MFLO, 0, 0, 8, 0, 0,   0,  0, 0, 4'hF, 0,  6'b000000, 0);
    add(0, R,    F_MFLO, 0, 0, 8, 0, 0,   1,  1, 0, 4'hF, 8,  6'b000000, 0);  // MFLO issues
    add(0, LW,   6'h0,   1, 5, 0, 0, 0,   1,  1, 1, 4'h2, 5,  6'b000000, 0);
    add(0, R,    F_ADD,  5, 6, 9, 0, 1,   0,  1, 1, 4'h2, 5,  6'b000000, 0);  // frozen
    add(0, R,    F_ADD,  5, 6, 9, 0, 1,   0,  1, 1, 4'h2, 5,  6'b000000, 0);
    add(0, R,    F_ADD,  5, 6, 9, 0, 1,   0,  1, 1, 4'h2, 5,  6'b000000, 0);
    add(0, R,    F_ADD,  5, 6, 9, 0, 0,   0,  0, 0, 4'hF, 0,  6'b000000, 0);  // stall resumes
    add(0, R,    F_ADD,  5, 6, 9, 0, 0,   1,  1, 0, 4'hF, 9,  6'b000000, 0);
    add(0, R,    F_MULT, 1, 2, 0, 0, 0,   1,  1, 0, 4'hF, 0,  6'b000001, 1);
    add(0, ADDI, 6'h0,   1, 4, 0, 0, 1,   0,  1, 0, 4'hF, 0,  6'b000001, 1);  // counter frozen
    add(0, ADDI, 6'h0,   1, 4, 0, 0, 1,   0,  1, 0, 4'hF, 0,  6'b000001, 1);
    add(0, ADDI, 6'h0,   1, 4, 0, 0, 0,   1,  1, 0, 4'h2, 4,  6'b000000, 1);
    add(0, ADDI, 6'h0,   1, 4, 0, 0, 0,   1,  1, 0, 4'h2, 4,  6'b000000, 1);
    add(0, ADDI, 6'h0,   1, 4, 0, 0, 0,   1,  1, 0, 4'h2, 4,  6'b000000, 1);
    add(0, ADDI, 6'h0,   1, 4, 0, 0, 0,   1,  1, 0, 4'h2, 4,  6'b000000, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].rd,
            vecs[i].fl, vecs[i].ms, got_pcw);
      check($sformatf("vec%0d pc_write", i), got_pcw, vecs[i].pcw);
      check($sformatf("vec%0d ex", i),
            {bus.ex_reg_write, bus.ex_mem_read, bus.ex_alu_op, bus.ex_wr_reg,
             bus.ex_link, bus.ex_jump, bus.ex_branch, bus.ex_branch_ne,
             bus.ex_illegal, bus.ex_md_start, bus.md_busy},
            {vecs[i].rw, vecs[i].mr, vecs[i].alu, vecs[i].wr, vecs[i].flags, vecs[i].busy});
      $display("vec %0d: op=%0h fn=%0h pc_write=%0b ex_wr_reg=%0d md_busy=%0b",
               i, vecs[i].op, vecs[i].fn, got_pcw, bus.ex_wr_reg, bus.md_busy);
    end

    for (int n = 0; n < 600; n++) begin
      op  = op_tab[$urandom_range(0, 13)];
      fn  = fn_tab[$urandom_range(0, 5)];
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 31));
      fl  = ($urandom_range(0, 9) == 0);
      ms  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 79) == 0);
      cycle(rst, op, fn, rs, rt, rd, fl, ms, got_pcw);
      $display("rnd %0d: rst=%0b op=%0h fn=%0h fl=%0b ms=%0b pc_write=%0b md_busy=%0b",
               n, rst, op, fn, fl, ms, got_pcw, bus.md_busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
